// File: rtl/openofdm_rx_ctrl_pkg.sv
// State and end-code encodings for the RX session sequencer; the same values
// appear in the driver's register map, so they must not be renumbered.
package openofdm_rx_ctrl_pkg;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StSync  = 3'd1;
    localparam logic [2:0] StHdr   = 3'd2;
    localparam logic [2:0] StData  = 3'd3;
    localparam logic [2:0] StFlush = 3'd4;
    localparam logic [2:0] StHold  = 3'd5;

    localparam logic [2:0] EndFcsOk  = 3'd0;
    localparam logic [2:0] EndFcsErr = 3'd1;
    localparam logic [2:0] EndHdrBad = 3'd2;
    localparam logic [2:0] EndToSync = 3'd3;
    localparam logic [2:0] EndToHdr  = 3'd4;
    localparam logic [2:0] EndToData = 3'd5;
    localparam logic [2:0] EndAbort  = 3'd6;

    function automatic logic is_active_state(input logic [2:0] st);
        return (st == StSync) || (st == StHdr) || (st == StData);
    endfunction

endpackage

// File: rtl/rx_ctrl_sat_cnt.sv
// Saturating statistics counter with synchronous clear; clear beats increment.
module rx_ctrl_sat_cnt #(
    parameter int unsigned STAT_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  inc_i,
    output logic [STAT_WIDTH-1:0] cnt_o
);

    logic [STAT_WIDTH-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + STAT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/openofdm_rx_ctrl.sv
// Receive-session sequencer beside dot11: tracks each packet, aborts stalled or
// unsupported ones with a timed core reset, and keeps per-outcome statistics.
module openofdm_rx_ctrl
    import openofdm_rx_ctrl_pkg::*;
#(
    parameter int unsigned TMO_WIDTH     = 20,
    parameter int unsigned STAT_WIDTH    = 16,
    parameter int unsigned RST_PULSE_LEN = 4
) (
    input  logic                  s00_axi_aclk_i,
    input  logic                  s00_axi_aresetn_i,
    input  logic                  cfg_enable_i,
    input  logic [TMO_WIDTH-1:0]  cfg_sync_timeout_i,
    input  logic [TMO_WIDTH-1:0]  cfg_hdr_timeout_i,
    input  logic [TMO_WIDTH-1:0]  cfg_byte_timeout_i,
    input  logic                  cfg_stat_clear_i,
    input  logic                  tx_busy_i,
    input  logic                  short_preamble_detected_i,
    input  logic                  long_preamble_detected_i,
    input  logic                  pkt_header_valid_strobe_i,
    input  logic                  pkt_header_valid_i,
    input  logic                  ht_unsupport_i,
    input  logic                  byte_out_strobe_i,
    input  logic                  fcs_out_strobe_i,
    input  logic                  fcs_ok_i,
    output logic                  core_rst_o,
    output logic                  core_enable_o,
    output logic                  rx_busy_o,
    output logic                  rx_end_strobe_o,
    output logic [2:0]            rx_end_code_o,
    output logic [2:0]            ctrl_state_o,
    output logic [STAT_WIDTH-1:0] cnt_fcs_ok_o,
    output logic [STAT_WIDTH-1:0] cnt_fcs_err_o,
    output logic [STAT_WIDTH-1:0] cnt_abort_o
);

    localparam int unsigned PulseW = (RST_PULSE_LEN > 1) ? $clog2(RST_PULSE_LEN) : 1;
    localparam logic [PulseW-1:0]    PulseLast = PulseW'(RST_PULSE_LEN - 1);
    localparam logic [TMO_WIDTH-1:0] TmoOne    = {{(TMO_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]           state_d, state_q;
    logic [PulseW-1:0]    pulse_d, pulse_q;
    logic [TMO_WIDTH-1:0] timer_d, timer_q;
    logic                 end_d, end_q;
    logic [2:0]           code_d, code_q;
    logic                 core_rst_q, core_en_q;
    logic                 sync_tmo, hdr_tmo, data_tmo;

    // A zero timeout config disables the corresponding timeout entirely.
    assign sync_tmo = (cfg_sync_timeout_i != '0) && (timer_q == cfg_sync_timeout_i - TmoOne);
    assign hdr_tmo  = (cfg_hdr_timeout_i  != '0) && (timer_q == cfg_hdr_timeout_i  - TmoOne);
    assign data_tmo = (cfg_byte_timeout_i != '0) && (timer_q == cfg_byte_timeout_i - TmoOne);

    always_comb begin
        state_d = state_q;
        end_d   = 1'b0;
        code_d  = code_q;
        if (!cfg_enable_i || tx_busy_i) begin
            state_d = StHold;
            if (is_active_state(state_q)) begin
                end_d  = 1'b1;
                code_d = EndAbort;
            end
        end else begin
            unique case (state_q)
                StHold:  state_d = StFlush;
                StFlush: if (pulse_q == PulseLast) state_d = StIdle;
                StIdle:  if (short_preamble_detected_i) state_d = StSync;
                StSync: begin
                    if (long_preamble_detected_i) begin
                        state_d = StHdr;
                    end else if (sync_tmo) begin
                        state_d = StFlush;
                        end_d   = 1'b1;
                        code_d  = EndToSync;
                    end
                end
                StHdr: begin
                    if (pkt_header_valid_strobe_i) begin
                        if (pkt_header_valid_i && !ht_unsupport_i) begin
                            state_d = StData;
                        end else begin
                            state_d = StFlush;
                            end_d   = 1'b1;
                            code_d  = EndHdrBad;
                        end
                    end else if (hdr_tmo) begin
                        state_d = StFlush;
                        end_d   = 1'b1;
                        code_d  = EndToHdr;
                    end
                end
                StData: begin
                    if (fcs_out_strobe_i) begin
                        state_d = StFlush;
                        end_d   = 1'b1;
                        code_d  = fcs_ok_i ? EndFcsOk : EndFcsErr;
                    end else if (!byte_out_strobe_i && data_tmo) begin
                        state_d = StFlush;
                        end_d   = 1'b1;
                        code_d  = EndToData;
                    end
                end
                default: state_d = StFlush;
            endcase
        end
    end

    // Timer restarts on every state change and, in DATA, on each payload byte.
    always_comb begin
        timer_d = timer_q + TmoOne;
        if (!is_active_state(state_d) || (state_d != state_q) ||
            ((state_q == StData) && byte_out_strobe_i)) begin
            timer_d = '0;
        end
        pulse_d = '0;
        if ((state_q == StFlush) && (state_d == StFlush)) begin
            pulse_d = pulse_q + PulseW'(1);
        end
    end

    always_ff @(posedge s00_axi_aclk_i or negedge s00_axi_aresetn_i) begin
        if (!s00_axi_aresetn_i) begin
            state_q    <= StFlush;
            pulse_q    <= '0;
            timer_q    <= '0;
            end_q      <= 1'b0;
            code_q     <= EndFcsOk;
            core_rst_q <= 1'b1;
            core_en_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            pulse_q    <= pulse_d;
            timer_q    <= timer_d;
            end_q      <= end_d;
            code_q     <= code_d;
            core_rst_q <= (state_d == StFlush) || (state_d == StHold);
            core_en_q  <= (state_d != StHold);
        end
    end

    assign core_rst_o      = core_rst_q;
    assign core_enable_o   = core_en_q;
    assign rx_busy_o       = is_active_state(state_q);
    assign rx_end_strobe_o = end_q;
    assign rx_end_code_o   = code_q;
    assign ctrl_state_o    = state_q;

    rx_ctrl_sat_cnt #(.STAT_WIDTH(STAT_WIDTH)) u_cnt_fcs_ok (
        .clk_i  (s00_axi_aclk_i),
        .rst_ni (s00_axi_aresetn_i),
        .clr_i  (cfg_stat_clear_i),
        .inc_i  (end_q && (code_q == EndFcsOk)),
        .cnt_o  (cnt_fcs_ok_o)
    );

    rx_ctrl_sat_cnt #(.STAT_WIDTH(STAT_WIDTH)) u_cnt_fcs_err (
        .clk_i  (s00_axi_aclk_i),
        .rst_ni (s00_axi_aresetn_i),
        .clr_i  (cfg_stat_clear_i),
        .inc_i  (end_q && (code_q == EndFcsErr)),
        .cnt_o  (cnt_fcs_err_o)
    );

    rx_ctrl_sat_cnt #(.STAT_WIDTH(STAT_WIDTH)) u_cnt_abort (
        .clk_i  (s00_axi_aclk_i),
        .rst_ni (s00_axi_aresetn_i),
        .clr_i  (cfg_stat_clear_i),
        .inc_i  (end_q && (code_q != EndFcsOk) && (code_q != EndFcsErr)),
        .cnt_o  (cnt_abort_o)
    );

endmodule
